// File: rtl/sdram_ahb_memtest_master_pkg.sv
// Shared definitions for the AHB3-Lite SDRAM memory-test master.
// Holds the AHB transfer encodings driven by the master and the
// sequencer state type.
package sdram_ahb_memtest_master_pkg;

  // AHB3-Lite HTRANS encodings. BUSY is never issued by this master.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Fixed control attributes: word beats, INCR4 bursts, privileged data access.
  localparam logic [2:0] HSIZE_WORD   = 3'b010;
  localparam logic [2:0] HBURST_INCR4 = 3'b011;
  localparam logic [3:0] HPROT_DATA   = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WDRAIN,
    ST_READ,
    ST_RDRAIN,
    ST_DONE
  } memtest_state_t;

endpackage

// File: rtl/sdram_ahb_memtest_master_if.sv
// AHB3-Lite point-to-point link between the memory-test master and one
// SDRAM controller port.
//   master modport : drives HSEL/HTRANS/HSIZE/HBURST/HPROT/HMASTLOCK/HWRITE/
//                    HADDR/HWDATA, receives HRDATA/HREADY/HRESP.
//   slave modport  : the mirror image.
interface sdram_ahb_memtest_master_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic                  HWRITE;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HSEL, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HADDR, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HADDR, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/sdram_memtest_pattern.sv
// Combinational test-pattern generator:
//   pat = addr ^ seed ^ (addr << 2), truncated/extended to HDATA_SIZE.
// Ports: addr (byte address), seed (run seed), pat (expected data word).
module sdram_memtest_pattern #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic [HADDR_SIZE-1:0] addr,
  input  logic [HDATA_SIZE-1:0] seed,
  output logic [HDATA_SIZE-1:0] pat
);
  logic [HADDR_SIZE-1:0] mix;

  // The shifted copy makes neighbouring words differ in more than the low
  // address bits, so stuck or bridged data lines show up quickly.
  assign mix = addr ^ {addr[HADDR_SIZE-3:0], 2'b00};
  assign pat = HDATA_SIZE'(mix) ^ seed;
endmodule

// File: rtl/sdram_ahb_memtest_master.sv
// AHB3-Lite memory-test master. On start it writes nbursts INCR4 word bursts
// of an address-derived pattern from base_addr_i, then reads the region back
// with the same burst sequence and checks every beat.
// Ports:
//   HCLK, HRESETn      clock, asynchronous active-low reset
//   start_i            run request, honoured only in IDLE/DONE
//   base_addr_i        16-byte aligned start address
//   nbursts_i          number of INCR4 bursts (0 = no transfers)
//   seed_i             pattern seed
//   busy_o / done_o    run in progress / one-cycle completion pulse
//   fail_o             sticky failure (mismatch, HRESP error, misaligned base)
//   errcnt_o           saturating count of mismatching read beats
//   first_err_addr_o   address of the first failure
//   ahb                AHB3-Lite master modport
module sdram_ahb_memtest_master
  import sdram_ahb_memtest_master_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int LEN_SIZE   = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  start_i,
  input  logic [HADDR_SIZE-1:0] base_addr_i,
  input  logic [LEN_SIZE-1:0]   nbursts_i,
  input  logic [HDATA_SIZE-1:0] seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [LEN_SIZE+1:0]   errcnt_o,
  output logic [HADDR_SIZE-1:0] first_err_addr_o,
  sdram_ahb_memtest_master_if.master ahb
);
  localparam int CNT_W = LEN_SIZE + 2;

  memtest_state_t        state;
  logic [HADDR_SIZE-1:0] base_q;
  logic [HADDR_SIZE-1:0] haddr;
  logic [HADDR_SIZE-1:0] dphase_addr;   // address whose data phase is on the bus
  logic                  dphase_valid;
  logic [HDATA_SIZE-1:0] seed_q;
  logic [HDATA_SIZE-1:0] hwdata;
  logic [HDATA_SIZE-1:0] wr_pat;
  logic [HDATA_SIZE-1:0] cmp_pat;
  logic [CNT_W-1:0]      beat_cnt;      // index of the beat in the address phase
  logic [CNT_W-1:0]      last_beat;
  logic [1:0]            htrans;
  logic                  hsel;
  logic                  hwrite;
  logic                  cmp_en;
  logic                  mismatch;

  sdram_memtest_pattern #(.HADDR_SIZE(HADDR_SIZE), .HDATA_SIZE(HDATA_SIZE)) u_wr_pat (
    .addr (haddr),
    .seed (seed_q),
    .pat  (wr_pat)
  );

  sdram_memtest_pattern #(.HADDR_SIZE(HADDR_SIZE), .HDATA_SIZE(HDATA_SIZE)) u_cmp_pat (
    .addr (dphase_addr),
    .seed (seed_q),
    .pat  (cmp_pat)
  );

  assign ahb.HSEL      = hsel;
  assign ahb.HTRANS    = htrans;
  assign ahb.HSIZE     = HSIZE_WORD;
  assign ahb.HBURST    = HBURST_INCR4;
  assign ahb.HPROT     = HPROT_DATA;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HWRITE    = hwrite;
  assign ahb.HADDR     = haddr;
  assign ahb.HWDATA    = hwdata;

  // A read beat is checked in the cycle its data phase completes.
  assign cmp_en   = ahb.HREADY && dphase_valid && (state == ST_READ || state == ST_RDRAIN);
  assign mismatch = (ahb.HRDATA != cmp_pat);

  // NOTE: state is updated only with non-blocking assignments, so every
  // branch below reads the values held at the start of the cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state            <= ST_IDLE;
      base_q           <= '0;
      haddr            <= '0;
      dphase_addr      <= '0;
      dphase_valid     <= 1'b0;
      seed_q           <= '0;
      hwdata           <= '0;
      beat_cnt         <= '0;
      last_beat        <= '0;
      htrans           <= HTRANS_IDLE;
      hsel             <= 1'b0;
      hwrite           <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      fail_o           <= 1'b0;
      errcnt_o         <= '0;
      first_err_addr_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            fail_o           <= 1'b0;
            errcnt_o         <= '0;
            first_err_addr_o <= '0;
            seed_q           <= seed_i;
            base_q           <= base_addr_i;
            last_beat        <= {nbursts_i, 2'b00} - CNT_W'(1);
            beat_cnt         <= '0;
            if (base_addr_i[3:0] != 4'h0) begin
              fail_o           <= 1'b1;
              first_err_addr_o <= base_addr_i;
              state            <= ST_DONE;
              done_o           <= 1'b1;
            end else if (nbursts_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state  <= ST_WRITE;
              busy_o <= 1'b1;
              hsel   <= 1'b1;
              hwrite <= 1'b1;
              htrans <= HTRANS_NONSEQ;
              haddr  <= base_addr_i;
            end
          end
        end

        default: begin
          if (ahb.HRESP) begin
            if (!ahb.HREADY) begin
              // First error cycle: cancel the pending address phase.
              htrans <= HTRANS_IDLE;
              fail_o <= 1'b1;
              if (!fail_o) first_err_addr_o <= dphase_addr;
            end else begin
              state        <= ST_DONE;
              done_o       <= 1'b1;
              busy_o       <= 1'b0;
              hsel         <= 1'b0;
              hwrite       <= 1'b0;
              htrans       <= HTRANS_IDLE;
              dphase_valid <= 1'b0;
            end
          end else if (ahb.HREADY) begin
            if (cmp_en && mismatch) begin
              fail_o <= 1'b1;
              if (errcnt_o != '1) errcnt_o <= errcnt_o + CNT_W'(1);
              if (!fail_o) first_err_addr_o <= dphase_addr;
            end

            case (state)
              ST_WRITE, ST_READ: begin
                if (htrans[1]) begin
                  dphase_valid <= 1'b1;
                  dphase_addr  <= haddr;
                  if (state == ST_WRITE) hwdata <= wr_pat;
                  if (beat_cnt == last_beat) begin
                    htrans <= HTRANS_IDLE;
                    state  <= (state == ST_WRITE) ? ST_WDRAIN : ST_RDRAIN;
                  end else begin
                    haddr    <= haddr + HADDR_SIZE'(4);
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    // Every fourth beat opens a new burst.
                    htrans   <= (beat_cnt[1:0] == 2'b11) ? HTRANS_NONSEQ : HTRANS_SEQ;
                  end
                end
              end

              ST_WDRAIN: begin
                dphase_valid <= 1'b0;
                state        <= ST_READ;
                haddr        <= base_q;
                hwrite       <= 1'b0;
                htrans       <= HTRANS_NONSEQ;
                beat_cnt     <= '0;
              end

              default: begin  // ST_RDRAIN: last read beat checked above
                state        <= ST_DONE;
                done_o       <= 1'b1;
                busy_o       <= 1'b0;
                hsel         <= 1'b0;
                htrans       <= HTRANS_IDLE;
                dphase_valid <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_ahb_memtest_master.sv
// Directed testbench for sdram_ahb_memtest_master with a behavioural
// AHB word-memory slave (configurable wait states, read corruption and a
// two-cycle error response at one address).
module tb_sdram_ahb_memtest_master;
  import sdram_ahb_memtest_master_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] nbursts_i = '0;
  logic [DW-1:0] seed_i = '0;
  logic          busy_o, done_o, fail_o;
  logic [LW+1:0] errcnt_o;
  logic [AW-1:0] first_err_addr_o;

  sdram_ahb_memtest_master_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) ahb ();

  sdram_ahb_memtest_master #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .LEN_SIZE(LW)) dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .start_i          (start_i),
    .base_addr_i      (base_addr_i),
    .nbursts_i        (nbursts_i),
    .seed_i           (seed_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .fail_o           (fail_o),
    .errcnt_o         (errcnt_o),
    .first_err_addr_o (first_err_addr_o),
    .ahb              (ahb)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration
  int          waits        = 0;
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
  logic [31:0] err_addr     = 32'hFFFF_FFFF;
  int          err_step     = 2;
  logic [31:0] mem [0:255];

  // Slave data-phase state
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr  = '0;
  int          wait_left = 0;

  // Bus values sampled in the middle of the previous cycle
  logic        s_valid = 1'b0;
  logic [1:0]  s_trans = '0;
  logic [31:0] s_addr  = '0;
  logic        s_write = 1'b0;
  logic [31:0] s_wdata = '0;
  logic        s_ready = 1'b1;
  logic        s_resp  = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [1:0]  trans;
  } beat_t;
  beat_t log_q[$];

  int         stab_viol = 0;
  logic       err_seen  = 1'b0;
  logic [1:0] err_trans = '0;

  function automatic logic [31:0] tb_pat(input logic [31:0] a, input logic [31:0] s);
    return a ^ s ^ {a[29:0], 2'b00};
  endfunction

  // Number of logged beats (starting at first_idx) that differ from the
  // expected INCR4 sequence starting at base.
  function automatic int seq_errors(input int first_idx, input logic [31:0] base,
                                    input int nbeats, input logic wr);
    int errs = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (first_idx + i >= log_q.size()) errs++;
      else if (log_q[first_idx+i].addr  !== base + 32'(4 * i) ||
               log_q[first_idx+i].write !== wr ||
               log_q[first_idx+i].trans !== ((i % 4 == 0) ? HTRANS_NONSEQ : HTRANS_SEQ))
        errs++;
    end
    return errs;
  endfunction

  function automatic int mem_errors(input logic [31:0] base, input int nwords,
                                    input logic [31:0] seed);
    int errs = 0;
    for (int i = 0; i < nwords; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      if (mem[a[9:2]] !== tb_pat(a, seed)) errs++;
    end
    return errs;
  endfunction

  // Bus monitor: logs accepted address phases, checks hold-during-wait.
  initial forever begin
    @(negedge HCLK);
    if (HRESETn) begin
      if (ahb.HREADY && ahb.HTRANS[1])
        log_q.push_back('{addr: ahb.HADDR, write: ahb.HWRITE, trans: ahb.HTRANS});
      if (s_valid && !s_ready && !s_resp &&
          (ahb.HADDR !== s_addr || ahb.HTRANS !== s_trans ||
           ahb.HWDATA !== s_wdata || ahb.HWRITE !== s_write))
        stab_viol++;
      if (s_valid && s_resp && !s_ready) begin
        err_seen  = 1'b1;
        err_trans = ahb.HTRANS;
      end
    end
    s_valid = HRESETn;
    s_trans = ahb.HTRANS;
    s_addr  = ahb.HADDR;
    s_write = ahb.HWRITE;
    s_wdata = ahb.HWDATA;
    s_ready = ahb.HREADY;
    s_resp  = ahb.HRESP;
  end

  // Behavioural slave, outputs updated just after each rising edge.
  initial begin
    ahb.HREADY = 1'b1;
    ahb.HRESP  = 1'b0;
    ahb.HRDATA = '0;
    forever begin
      @(posedge HCLK);
      #1;
      if (!HRESETn) begin
        dp_valid   = 1'b0;
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 1'b0;
      end else begin
        if (s_ready) begin
          if (dp_valid && dp_write) mem[dp_addr[9:2]] = s_wdata;
          dp_valid  = s_trans[1];
          dp_write  = s_write;
          dp_addr   = s_addr;
          wait_left = waits;
        end
        if (dp_valid && dp_addr == err_addr && err_step == 0) begin
          ahb.HRESP = 1'b1; ahb.HREADY = 1'b0; err_step = 1;
        end else if (err_step == 1) begin
          ahb.HRESP = 1'b1; ahb.HREADY = 1'b1; err_step = 2;
        end else if (dp_valid && wait_left > 0) begin
          ahb.HRESP = 1'b0; ahb.HREADY = 1'b0; wait_left--;
        end else begin
          ahb.HRESP  = 1'b0;
          ahb.HREADY = 1'b1;
          ahb.HRDATA = (dp_valid && !dp_write)
                     ? (mem[dp_addr[9:2]] ^ ((dp_addr == corrupt_addr) ? 32'h1 : 32'h0))
                     : 32'h0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
    @(negedge HCLK);
    base_addr_i = b;
    nbursts_i   = n;
    seed_i      = s;
    start_i     = 1'b1;
    @(posedge HCLK);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge HCLK);
      if (done_o) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    n_checks++;
    if ({ahb.HTRANS, ahb.HSEL, ahb.HWRITE, ahb.HMASTLOCK} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {ahb.HTRANS, ahb.HSEL, ahb.HWRITE, ahb.HMASTLOCK});
    end
    n_checks++;
    if ({ahb.HSIZE, ahb.HBURST, ahb.HPROT} !== {3'b010, 3'b011, 4'b0011}) begin
      n_fail++;
      $display("FAIL reset_attr: got %b expected 0100110011", {ahb.HSIZE, ahb.HBURST, ahb.HPROT});
    end
    n_checks++;
    if (ahb.HADDR !== 32'h0 || ahb.HWDATA !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got %h/%h expected 0/0", ahb.HADDR, ahb.HWDATA);
    end
    n_checks++;
    if ({busy_o, done_o, fail_o} !== 3'b000 || errcnt_o !== '0 || first_err_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_status: got %b cnt=%0d addr=%h expected 000 0 0",
               {busy_o, done_o, fail_o}, errcnt_o, first_err_addr_o);
    end
  endtask

  task automatic test_basic;
    bit got;
    int e;
    log_q.delete();
    do_start(32'h100, 16'd2, 32'h0);
    @(negedge HCLK);
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy_o); end
    wait_done(200, got);
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", got); end
    n_checks++;
    if (log_q.size() !== 16) begin n_fail++; $display("FAIL basic_beats: got %0d expected 16", log_q.size()); end
    e = seq_errors(0, 32'h100, 8, 1'b1);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL basic_write_seq: got %0d bad beats expected 0", e); end
    e = seq_errors(8, 32'h100, 8, 1'b0);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL basic_read_seq: got %0d bad beats expected 0", e); end
    e = mem_errors(32'h100, 8, 32'h0);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL basic_wdata: got %0d bad words expected 0", e); end
    n_checks++;
    if ({busy_o, fail_o} !== 2'b00 || errcnt_o !== '0) begin
      n_fail++;
      $display("FAIL basic_status: got busy=%b fail=%b cnt=%0d expected 0 0 0", busy_o, fail_o, errcnt_o);
    end
    @(negedge HCLK);
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done_o); end
  endtask

  task automatic test_wait_states;
    bit got;
    int e;
    waits = 2;
    stab_viol = 0;
    log_q.delete();
    do_start(32'h100, 16'd2, 32'hA5A5_0F0F);
    wait_done(500, got);
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL wait_done: got %b expected 1", got); end
    n_checks++;
    if (stab_viol !== 0) begin n_fail++; $display("FAIL wait_hold: got %0d changes expected 0", stab_viol); end
    e = seq_errors(0, 32'h100, 8, 1'b1) + seq_errors(8, 32'h100, 8, 1'b0);
    n_checks++;
    if (e !== 0 || log_q.size() !== 16) begin
      n_fail++;
      $display("FAIL wait_seq: got %0d bad of %0d beats expected 0 of 16", e, log_q.size());
    end
    e = mem_errors(32'h100, 8, 32'hA5A5_0F0F);
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL wait_wdata: got %0d bad words expected 0", e); end
    n_checks++;
    if (fail_o !== 1'b0 || errcnt_o !== '0) begin
      n_fail++;
      $display("FAIL wait_status: got fail=%b cnt=%0d expected 0 0", fail_o, errcnt_o);
    end
    waits = 0;
  endtask

  task automatic test_corrupt;
    bit got;
    corrupt_addr = 32'h108;
    log_q.delete();
    do_start(32'h100, 16'd2, 32'h1234_5678);
    wait_done(200, got);
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL corrupt_done: got %b expected 1", got); end
    n_checks++;
    if (errcnt_o !== 18'd1) begin n_fail++; $display("FAIL corrupt_errcnt: got %0d expected 1", errcnt_o); end
    n_checks++;
    if (fail_o !== 1'b1) begin n_fail++; $display("FAIL corrupt_fail: got %b expected 1", fail_o); end
    n_checks++;
    if (first_err_addr_o !== 32'h108) begin
      n_fail++;
      $display("FAIL corrupt_addr: got %h expected 00000108", first_err_addr_o);
    end
    corrupt_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_hresp;
    bit got;
    int e;
    err_addr = 32'h104;
    err_step = 0;
    err_seen = 1'b0;
    log_q.delete();
    do_start(32'h100, 16'd2, 32'h0);
    wait_done(50, got);
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL hresp_done: got %b expected 1", got); end
    n_checks++;
    if (err_seen !== 1'b1 || err_trans !== HTRANS_IDLE) begin
      n_fail++;
      $display("FAIL hresp_cancel: got seen=%b htrans=%b expected 1 00", err_seen, err_trans);
    end
    e = seq_errors(0, 32'h100, 2, 1'b1);
    n_checks++;
    if (log_q.size() !== 2 || e !== 0) begin
      n_fail++;
      $display("FAIL hresp_beats: got %0d beats (%0d bad) expected 2 writes, no reads", log_q.size(), e);
    end
    n_checks++;
    if (fail_o !== 1'b1 || first_err_addr_o !== 32'h104) begin
      n_fail++;
      $display("FAIL hresp_status: got fail=%b addr=%h expected 1 00000104", fail_o, first_err_addr_o);
    end
    err_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_misaligned;
    bit got;
    log_q.delete();
    do_start(32'h104, 16'd2, 32'h0);
    wait_done(5, got);
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL misalign_done: got %b expected 1", got); end
    repeat (3) @(negedge HCLK);
    n_checks++;
    if (log_q.size() !== 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_bus: got %0d beats busy=%b expected 0 0", log_q.size(), busy_o);
    end
    n_checks++;
    if (fail_o !== 1'b1 || first_err_addr_o !== 32'h104) begin
      n_fail++;
      $display("FAIL misalign_status: got fail=%b addr=%h expected 1 00000104", fail_o, first_err_addr_o);
    end
  endtask

  task automatic test_zero_bursts;
    bit got;
    log_q.delete();
    do_start(32'h200, 16'd0, 32'h0);
    wait_done(5, got);
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", got); end
    n_checks++;
    if (fail_o !== 1'b0 || log_q.size() !== 0) begin
      n_fail++;
      $display("FAIL zero_status: got fail=%b beats=%0d expected 0 0", fail_o, log_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    bit found;
    int e;
    found = 1'b0;
    log_q.delete();
    do_start(32'h100, 16'd2, 32'h0);
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge HCLK);
      if (ahb.HTRANS[1] && !ahb.HWRITE && ahb.HADDR == 32'h10C) found = 1'b1;
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL rst_reach_beat3: got %b expected 1", found); end
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    n_checks++;
    if (ahb.HTRANS !== HTRANS_IDLE || busy_o !== 1'b0 || errcnt_o !== '0 || ahb.HSEL !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got htrans=%b busy=%b cnt=%0d hsel=%b expected 00 0 0 0",
               ahb.HTRANS, busy_o, errcnt_o, ahb.HSEL);
    end
    @(negedge HCLK);
    #2;
    HRESETn = 1'b1;
    log_q.delete();
    do_start(32'h300, 16'd1, 32'hDEAD_BEEF);
    wait_done(200, got);
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL rst_rerun_done: got %b expected 1", got); end
    e = seq_errors(0, 32'h300, 4, 1'b1) + seq_errors(4, 32'h300, 4, 1'b0);
    n_checks++;
    if (e !== 0 || log_q.size() !== 8) begin
      n_fail++;
      $display("FAIL rst_rerun_seq: got %0d bad of %0d beats expected 0 of 8", e, log_q.size());
    end
    n_checks++;
    if (fail_o !== 1'b0 || errcnt_o !== '0) begin
      n_fail++;
      $display("FAIL rst_rerun_status: got fail=%b cnt=%0d expected 0 0", fail_o, errcnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_corrupt();
    test_hresp();
    test_misaligned();
    test_zero_bursts();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
